// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter: round-robin grant held for a whole cyc period,
// combinational request/response routing, and a stall watchdog that injects a one-cycle err.
module wb_rr_arbiter #(
  parameter int unsigned nm      = 3,
  parameter int unsigned aw      = 32,
  parameter int unsigned dw      = 32,
  parameter int unsigned timeout = 256,
  parameter int unsigned cw      = 9
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [nm*aw-1:0]       wbm_adr_i,
  input  logic [nm*dw-1:0]       wbm_dat_i,
  input  logic [nm*(dw/8)-1:0]   wbm_sel_i,
  input  logic [nm*3-1:0]        wbm_cti_i,
  input  logic [nm*2-1:0]        wbm_bte_i,
  input  logic [nm-1:0]          wbm_we_i,
  input  logic [nm-1:0]          wbm_cyc_i,
  input  logic [nm-1:0]          wbm_stb_i,
  output logic [dw-1:0]          wbm_dat_o,
  output logic [nm-1:0]          wbm_ack_o,
  output logic [nm-1:0]          wbm_err_o,
  output logic [nm-1:0]          wbm_rty_o,
  output logic [aw-1:0]          wbs_adr_o,
  output logic [dw-1:0]          wbs_dat_o,
  output logic [dw/8-1:0]        wbs_sel_o,
  output logic [2:0]             wbs_cti_o,
  output logic [1:0]             wbs_bte_o,
  output logic                   wbs_we_o,
  output logic                   wbs_cyc_o,
  output logic                   wbs_stb_o,
  input  logic [dw-1:0]          wbs_dat_i,
  input  logic                   wbs_ack_i,
  input  logic                   wbs_err_i,
  input  logic                   wbs_rty_i,
  output logic [nm-1:0]          grant_o
);

  localparam int unsigned Iw = (nm > 1) ? $clog2(nm) : 1;
  localparam int unsigned Sw = dw / 8;
  localparam logic [cw-1:0] TimeoutM1 = cw'(timeout - 1);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e          state_q, state_d;
  logic [nm-1:0]   grant_q, grant_d;
  logic [Iw-1:0]   last_q, last_d;
  logic [cw-1:0]   cnt_q, cnt_d;
  logic            found;
  logic            g_cyc, g_stb;
  logic            stall, wd_fire;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= Iw'(nm - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Round-robin search: offset j=1 is the master right after the last owner.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    found   = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int unsigned j = 1; j <= nm; j++) begin
          for (int unsigned k = 0; k < nm; k++) begin
            if (!found && wbm_cyc_i[k] && (k == (32'(last_q) + j) % nm)) begin
              found      = 1'b1;
              grant_d    = '0;
              grant_d[k] = 1'b1;
              last_d     = Iw'(k);
              state_d    = StOwned;
            end
          end
        end
      end
      StOwned: begin
        if (!(|(grant_q & wbm_cyc_i))) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // One-hot AND-OR mux; everything stays 0 while no grant is held.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_we_o  = 1'b0;
    g_cyc     = 1'b0;
    g_stb     = 1'b0;
    for (int unsigned k = 0; k < nm; k++) begin
      if (grant_q[k]) begin
        wbs_adr_o = wbm_adr_i[k*aw +: aw];
        wbs_dat_o = wbm_dat_i[k*dw +: dw];
        wbs_sel_o = wbm_sel_i[k*Sw +: Sw];
        wbs_cti_o = wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbm_bte_i[k*2 +: 2];
        wbs_we_o  = wbm_we_i[k];
        g_cyc     = wbm_cyc_i[k];
        g_stb     = wbm_stb_i[k];
      end
    end
  end

  assign wbs_cyc_o = g_cyc;
  assign wbs_stb_o = g_stb & g_cyc;

  assign stall = g_cyc & g_stb & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);

  always_comb begin
    wd_fire = 1'b0;
    cnt_d   = '0;
    if (timeout > 0) begin
      wd_fire = stall && (cnt_q == TimeoutM1);
      if (stall && !wd_fire && (grant_d == grant_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = grant_q & {nm{wbs_ack_i}};
  assign wbm_err_o = grant_q & {nm{wbs_err_i | wd_fire}};
  assign wbm_rty_o = grant_q & {nm{wbs_rty_i}};
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (3 masters, watchdog timeout 8): vectors with
// hand-derived expected grant/response/slave-bus values, compared through a scoreboard queue.
module tb_wb_rr_arbiter;

  localparam int unsigned Nm = 3;
  localparam int unsigned Aw = 32;
  localparam int unsigned Dw = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [Nm*Aw-1:0]  m_adr;
  logic [Nm*Dw-1:0]  m_dat;
  logic [Nm*4-1:0]   m_sel;
  logic [Nm*3-1:0]   m_cti;
  logic [Nm*2-1:0]   m_bte;
  logic [Nm-1:0]     m_we, m_cyc, m_stb;
  logic [Dw-1:0]     m_dat_o;
  logic [Nm-1:0]     m_ack, m_err, m_rty;
  logic [Aw-1:0]     s_adr;
  logic [Dw-1:0]     s_dat_o, s_dat_i;
  logic [3:0]        s_sel;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic              s_we, s_cyc, s_stb;
  logic              s_ack, s_err, s_rty;
  logic [Nm-1:0]     grant;

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  wb_rr_arbiter #(
    .nm(Nm), .aw(Aw), .dw(Dw), .timeout(8), .cw(9)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbm_adr_i(m_adr),
    .wbm_dat_i(m_dat),
    .wbm_sel_i(m_sel),
    .wbm_cti_i(m_cti),
    .wbm_bte_i(m_bte),
    .wbm_we_i (m_we),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_dat_o(m_dat_o),
    .wbm_ack_o(m_ack),
    .wbm_err_o(m_err),
    .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr),
    .wbs_dat_o(s_dat_o),
    .wbs_sel_o(s_sel),
    .wbs_cti_o(s_cti),
    .wbs_bte_o(s_bte),
    .wbs_we_o (s_we),
    .wbs_cyc_o(s_cyc),
    .wbs_stb_o(s_stb),
    .wbs_dat_i(s_dat_i),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(s_rty),
    .grant_o  (grant)
  );

  always #5 clk = ~clk;

  // resp = {ack, err, rty}; es = {slave cyc, slave stb} expected.
  typedef struct {
    logic        rst;
    logic [2:0]  cyc, stb, resp, cti1;
    logic [2:0]  gnt, eack, eerr, erty;
    logic [1:0]  es;
    logic [31:0] sdat;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t v(input logic rst_v, input logic [2:0] cyc, input logic [2:0] stb,
                             input logic [2:0] resp, input logic [2:0] cti1,
                             input logic [2:0] gnt, input logic [2:0] eack,
                             input logic [2:0] eerr, input logic [2:0] erty,
                             input logic [1:0] es);
    vec_t r;
    r.rst = rst_v; r.cyc = cyc; r.stb = stb; r.resp = resp; r.cti1 = cti1;
    r.gnt = gnt; r.eack = eack; r.eerr = eerr; r.erty = erty; r.es = es; r.sdat = '0;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, step_no, got, want);
    end
  endtask

  task automatic compare(input vec_t e);
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic [1:0]  e_bte;
    logic        e_we;
    e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0; e_bte = '0; e_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (e.gnt[k]) begin
        e_adr = 32'h1000_0000 + 32'(k) * 32'h100;
        e_dat = 32'hD000_0000 + 32'(k);
        e_sel = 4'(4'b0001 << k);
        e_cti = (k == 1) ? e.cti1 : ((k == 0) ? 3'b001 : 3'b011);
        e_bte = 2'(k);
        e_we  = (k != 1);
      end
    end
    check("grant", 128'(grant), 128'(e.gnt));
    check("resp", 128'({m_ack, m_err, m_rty}), 128'({e.eack, e.eerr, e.erty}));
    check("slave_bus", 128'({s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel, s_cti, s_bte}),
          128'({e.es, e_we, e_adr, e_dat, e_sel, e_cti, e_bte}));
    check("rdata", 128'(m_dat_o), 128'(e.sdat));
  endtask

  task automatic step(input vec_t x);
    @(posedge clk);
    #1;
    x.sdat = $urandom;
    rst = x.rst;
    m_cyc = x.cyc;
    m_stb = x.stb;
    {s_ack, s_err, s_rty} = x.resp;
    m_cti[5:3] = x.cti1;
    s_dat_i = x.sdat;
    exp_q.push_back(x);
    @(negedge clk);
    step_no++;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue want one entry", step_no);
    end else begin
      compare(exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_i = '0;
    m_we = 3'b101;
    for (int k = 0; k < 3; k++) begin
      m_adr[k*32 +: 32] = 32'h1000_0000 + 32'(k) * 32'h100;
      m_dat[k*32 +: 32] = 32'hD000_0000 + 32'(k);
      m_sel[k*4 +: 4]   = 4'(4'b0001 << k);
      m_bte[k*2 +: 2]   = 2'(k);
    end
    m_cti = {3'b011, 3'b000, 3'b001};
    repeat (2) @(posedge clk);

    // Reset state, single request, then 3-way round robin with idle gaps.
    tbl.push_back(v(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'b11));
    tbl.push_back(v(0, 3'b001, 3'b001, 3'b100, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 2'b11));
    tbl.push_back(v(0, 3'b111, 3'b111, 3'b100, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 2'b11));
    tbl.push_back(v(0, 3'b110, 3'b110, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b110, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b110, 3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 2'b11));
    tbl.push_back(v(0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b101, 3'b101, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 2'b11));
    tbl.push_back(v(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b001, 3'b001, 3'b100, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 2'b11));
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    // rty and err routed only to the owner; foreign cyc ignored while owned.
    tbl.push_back(v(0, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b011, 3'b010, 3'b001, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010, 2'b11));
    tbl.push_back(v(0, 3'b011, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 2'b11));
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'b10));
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'b00));
    tbl.push_back(v(0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Master 1 burst while master 0 requests; grant then passes to master 0.
    step(v(0, 3'b011, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    for (int b = 0; b < 4; b++) begin
      step(v(0, 3'b011, 3'b010, 3'b100, (b == 3) ? 3'b111 : 3'b010,
             3'b010, 3'b010, 3'b000, 3'b000, 2'b11));
    end
    step(v(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 2'b00));
    step(v(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    step(v(0, 3'b001, 3'b001, 3'b100, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 2'b11));
    step(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'b00));
    step(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));

    // Watchdog: pulses on stall cycles 8 and 16; slave err on cycle 24 is not doubled.
    step(v(0, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    for (int s = 1; s <= 26; s++) begin
      step(v(0, 3'b100, 3'b100, (s == 24) ? 3'b010 : 3'b000, 3'b000, 3'b100, 3'b000,
             (s == 8 || s == 16 || s == 24) ? 3'b100 : 3'b000, 3'b000, 2'b11));
    end
    step(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 2'b00));
    step(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));

    // Reset mid-burst, then master 0 wins 3-way contention.
    step(v(0, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    step(v(0, 3'b010, 3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 2'b11));
    step(v(1, 3'b111, 3'b111, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 2'b11));
    step(v(0, 3'b111, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));
    step(v(0, 3'b111, 3'b111, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 2'b11));
    step(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'b00));
    step(v(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
